// File: rtl/vedic_mac_pkg.sv
// Shared constants and types for the Vedic MAC accumulator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: default operand/guard/count widths, FSM state type, sticky
// error-flag bit positions.
package vedic_mac_pkg;

  localparam int N_DEF  = 32;
  localparam int G_DEF  = 8;
  localparam int CW_DEF = 8;
  localparam int AW_DEF = 2*N_DEF + G_DEF;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  // Bit positions inside the sticky error vector.
  localparam int ERR_OVERRUN = 0;
  localparam int ERR_STRAY   = 1;
  localparam int ERR_W       = 2;

endpackage

// File: rtl/vedic_mac_acc_core.sv
// Combinational accumulator adder with carry detect and optional clamp.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: base/addend (AW) -> sum (AW), carry (carry out of bit AW-1).
// Build option: VEDIC_MAC_SATURATE_EN clamps sum to all-ones on carry;
// without it the sum wraps modulo 2^AW.
module vedic_mac_acc_core #(
  parameter int AW = 72
) (
  input  logic [AW-1:0] base,
  input  logic [AW-1:0] addend,
  output logic [AW-1:0] sum,
  output logic          carry
);

  logic [AW:0] raw;

  assign raw   = {1'b0, base} + {1'b0, addend};
  assign carry = raw[AW];

`ifdef VEDIC_MAC_SATURATE_EN
  // Once clamped, any further non-zero add carries again and re-clamps,
  // so the accumulator naturally stays at all-ones for the block.
  assign sum = carry ? {AW{1'b1}} : raw[AW-1:0];
`else
  assign sum = raw[AW-1:0];
`endif

endmodule

// File: rtl/vedic_mac_accumulator.sv
// Sums cfg_len consecutive unsigned 2N-bit products into an AW-bit accumulator.
// Latency: sum visible on out_sum/out_valid 1 cycle after the last product.
// Backpressure: never stalls products; an undelivered sum that gets
// overwritten raises sticky err_overrun instead of blocking.
// Ports: clk, rst_n (async active-low); start/cfg_len begin a block;
// prod_valid/prod product stream; busy while accumulating; out_valid/
// out_ready/out_sum/out_ovf result handshake; err_overrun/err_stray sticky
// flags cleared by clr_err (a same-cycle set wins).
// Build option: VEDIC_MAC_SATURATE_EN selects clamp instead of wrap.
module vedic_mac_accumulator
  import vedic_mac_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int G  = G_DEF,
  parameter int CW = CW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CW-1:0]     cfg_len,
  input  logic              prod_valid,
  input  logic [2*N-1:0]    prod,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*N+G-1:0]  out_sum,
  output logic              out_ovf,
  output logic              err_overrun,
  output logic              err_stray,
  input  logic              clr_err
);

  localparam int AW = 2*N + G;

  state_t          state;
  logic [AW-1:0]   acc;
  logic [CW-1:0]   rem;
  logic            blk_ovf;
  logic [ERR_W-1:0] err_q;

  logic            in_acc;
  logic            take;
  logic [CW-1:0]   eff_len;
  logic [CW-1:0]   rem_base;
  logic [CW-1:0]   rem_next;
  logic [AW-1:0]   core_base;
  logic [AW-1:0]   core_add;
  logic [AW-1:0]   core_sum;
  logic            core_carry;
  logic            blk_ovf_next;
  logic            done;
  logic            accepted;
  logic [ERR_W-1:0] err_set;

  assign in_acc  = (state == ACCUM);
  // A product is consumed only by an opening start or an open block.
  assign take    = prod_valid & (start | in_acc);
  assign eff_len = (cfg_len == '0) ? CW'(1) : cfg_len;

  // start restarts the count from the new length; otherwise keep counting.
  assign rem_base = start ? eff_len : rem;
  assign rem_next = rem_base - CW'(take);

  assign core_base = start ? '0 : acc;
  assign core_add  = take ? {{G{1'b0}}, prod} : '0;

  vedic_mac_acc_core #(.AW(AW)) u_core (
    .base   (core_base),
    .addend (core_add),
    .sum    (core_sum),
    .carry  (core_carry)
  );

  // start drops the previous block's overflow history.
  assign blk_ovf_next = (start ? 1'b0 : blk_ovf) | (take & core_carry);

  // In ACCUM rem is never zero, so without a take rem_next cannot hit zero
  // unless start just loaded a length that the same-cycle product exhausts.
  assign done     = (start | take) & (rem_next == '0);
  assign accepted = out_valid & out_ready;

  always_comb begin
    err_set              = '0;
    err_set[ERR_OVERRUN] = done & out_valid & ~out_ready;
    err_set[ERR_STRAY]   = prod_valid & ~start & ~in_acc;
  end

  assign err_overrun = err_q[ERR_OVERRUN];
  assign err_stray   = err_q[ERR_STRAY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      acc       <= '0;
      rem       <= '0;
      blk_ovf   <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
      err_q     <= '0;
    end else begin
      if (done) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else if (start) begin
        state <= ACCUM;
        busy  <= 1'b1;
      end

      if (start | take) begin
        acc     <= core_sum;
        rem     <= rem_next;
        blk_ovf <= blk_ovf_next;
      end

      // A completing block always loads, whether or not the held sum left.
      if (done) begin
        out_sum   <= core_sum;
        out_ovf   <= blk_ovf_next;
        out_valid <= 1'b1;
      end else if (accepted) begin
        out_valid <= 1'b0;
      end

      err_q <= err_set | (err_q & {ERR_W{~clr_err}});
    end
  end

endmodule

// File: tb/tb_vedic_mac_accumulator.sv
module tb_vedic_mac_accumulator;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  cfg_len;
  logic        prod_valid;
  logic [63:0] prod;
  logic        out_ready;
  logic        clr_err;

  // Default-width instance (AW=72) and a narrow-guard instance (AW=65)
  // sharing one stimulus stream so overflow is reachable.
  logic        busy0, out_valid0, out_ovf0, err_overrun0, err_stray0;
  logic [71:0] out_sum0;
  logic        busy1, out_valid1, out_ovf1, err_overrun1, err_stray1;
  logic [64:0] out_sum1;

  vedic_mac_accumulator dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len),
    .prod_valid(prod_valid), .prod(prod), .busy(busy0),
    .out_valid(out_valid0), .out_ready(out_ready), .out_sum(out_sum0),
    .out_ovf(out_ovf0), .err_overrun(err_overrun0), .err_stray(err_stray0),
    .clr_err(clr_err)
  );

  vedic_mac_accumulator #(.G(1)) dut_g1 (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len),
    .prod_valid(prod_valid), .prod(prod), .busy(busy1),
    .out_valid(out_valid1), .out_ready(out_ready), .out_sum(out_sum1),
    .out_ovf(out_ovf1), .err_overrun(err_overrun1), .err_stray(err_stray1),
    .clr_err(clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [71:0] s0;
    logic        o0;
    logic [71:0] s1;
    logic        o1;
  } exp_t;

  exp_t        q[$];
  logic [71:0] m_sum[2];
  logic        m_ovf[2];
  bit          m_in;
  int          m_rem;
  bit          m_ovr;
  bit          m_str;

  function automatic void madd(input int i, input logic [63:0] p);
    logic [72:0] lim;
    logic [72:0] t;
    int          aw;
    aw  = (i == 0) ? 72 : 65;
    lim = (73'd1 << aw) - 73'd1;
    t   = {1'b0, m_sum[i]} + {9'd0, p};
    if (t > lim) begin
      m_ovf[i] = 1'b1;
`ifdef VEDIC_MAC_SATURATE_EN
      t = lim;
`else
      t = t - (lim + 73'd1);
`endif
    end
    m_sum[i] = t[71:0];
  endfunction

  task automatic model_reset();
    q.delete();
    m_in  = 0;
    m_rem = 0;
    m_ovr = 0;
    m_str = 0;
    for (int i = 0; i < 2; i++) begin
      m_sum[i] = '0;
      m_ovf[i] = 1'b0;
    end
  endtask

  task automatic model_step();
    bit   done;
    bit   set_ov;
    bit   set_st;
    exp_t e;
    done = 0; set_ov = 0; set_st = 0;
    if (start) begin
      m_rem = (cfg_len == 0) ? 1 : int'(cfg_len);
      m_in  = 1;
      for (int i = 0; i < 2; i++) begin
        m_sum[i] = '0;
        m_ovf[i] = 1'b0;
      end
      if (prod_valid) begin
        madd(0, prod); madd(1, prod);
        m_rem--;
      end
      done = (m_rem == 0);
    end else if (m_in && prod_valid) begin
      madd(0, prod); madd(1, prod);
      m_rem--;
      done = (m_rem == 0);
    end else if (!m_in && prod_valid) begin
      set_st = 1;
    end
    if (done) begin
      m_in = 0;
      e.s0 = m_sum[0]; e.o0 = m_ovf[0];
      e.s1 = m_sum[1]; e.o1 = m_ovf[1];
      // Anything still queued here was not accepted before this edge.
      if (q.size() > 0) begin
        q[q.size()-1] = e;
        set_ov = 1;
      end else begin
        q.push_back(e);
      end
    end
    m_ovr = set_ov | (m_ovr & !clr_err);
    m_str = set_st | (m_str & !clr_err);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    exp_t e;
    chk("out_valid",    {71'd0, out_valid0},   {71'd0, q.size() != 0});
    chk("out_valid_g1", {71'd0, out_valid1},   {71'd0, q.size() != 0});
    chk("busy",         {71'd0, busy0},        {71'd0, m_in});
    chk("busy_g1",      {71'd0, busy1},        {71'd0, m_in});
    chk("err_overrun",  {71'd0, err_overrun0}, {71'd0, m_ovr});
    chk("err_stray",    {71'd0, err_stray0},   {71'd0, m_str});
    chk("err_flags_g1", {70'd0, err_overrun1, err_stray1}, {70'd0, m_ovr, m_str});
    if (out_valid0 && out_ready) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_output: got sum %h, expected no result", out_sum0);
      end else begin
        e = q.pop_front();
        chk("out_sum",    out_sum0,           e.s0);
        chk("out_ovf",    {71'd0, out_ovf0},  {71'd0, e.o0});
        chk("out_sum_g1", {7'd0, out_sum1},   e.s1);
        chk("out_ovf_g1", {71'd0, out_ovf1},  {71'd0, e.o1});
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  task automatic idle_inputs();
    start = 0; cfg_len = 0; prod_valid = 0; prod = '0; clr_err = 0;
  endtask

  task automatic do_start(input logic [7:0] len);
    idle_inputs(); start = 1; cfg_len = len; tick(); idle_inputs();
  endtask

  task automatic do_prod(input logic [63:0] p);
    idle_inputs(); prod_valid = 1; prod = p; tick(); idle_inputs();
  endtask

  task automatic do_idle(input int n);
    idle_inputs();
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_reset(input int n);
    rst_n = 0;
    model_reset();
    do_idle(n);
    rst_n = 1;
  endtask

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    idle_inputs();
    out_ready = 1;
    rst_n     = 1;
    model_reset();
    #1;
    do_reset(3);
    chk("reset_out_sum",    out_sum0,             72'd0);
    chk("reset_out_sum_g1", {7'd0, out_sum1},     72'd0);

    // 5 + 7 + 11
    do_start(8'd3);
    do_prod(64'd5);
    do_prod(64'd7);
    do_prod(64'd11);
    chk("sum_3_terms", out_sum0, 72'd23);
    do_idle(2);

    // Single-term block taken together with start.
    idle_inputs(); start = 1; cfg_len = 8'd1; prod_valid = 1; prod = ONES; tick();
    chk("len1_same_cycle", out_sum0, 72'h00_FFFF_FFFF_FFFF_FFFF);
    do_idle(2);

    // 255 all-ones terms: fits in 72 bits, overflows the 65-bit instance.
    do_start(8'd255);
    for (int k = 0; k < 255; k++) do_prod(ONES);
    chk("len255_sum", out_sum0, 72'hFE_FFFF_FFFF_FFFF_FF01);
`ifdef VEDIC_MAC_SATURATE_EN
    chk("len255_sum_g1", {7'd0, out_sum1}, {7'd0, {65{1'b1}}});
`else
    chk("len255_sum_g1", {7'd0, out_sum1}, 72'h00_FFFF_FFFF_FFFF_FF01);
`endif
    chk("len255_ovf_g1", {71'd0, out_ovf1}, 72'd1);
    do_idle(2);

    // Overrun: two blocks complete while the consumer is stalled.
    out_ready = 0;
    do_start(8'd1); do_prod(64'd10);
    do_start(8'd1); do_prod(64'd20);
    do_idle(2);
    chk("overrun_held_sum", out_sum0, 72'd20);
    out_ready = 1;
    do_idle(2);
    idle_inputs(); clr_err = 1; tick(); idle_inputs();
    do_idle(1);

    // Reset in the middle of a block discards it.
    do_start(8'd4); do_prod(64'd1); do_prod(64'd2);
    do_reset(2);
    do_idle(2);
    do_start(8'd2); do_prod(64'd4); do_prod(64'd5);
    chk("after_reset_sum", out_sum0, 72'd9);
    do_idle(2);

    // Stray product, then an aborted block followed by a fresh one.
    do_prod(64'd99);
    do_idle(1);
    do_start(8'd4); do_prod(64'd100); do_prod(64'd200);
    do_start(8'd2); do_prod(64'd3); do_prod(64'd4);
    chk("abort_restart_sum", out_sum0, 72'd7);
    do_idle(2);

    // Randomized traffic, including cfg_len=0 and same-cycle accept+complete.
    for (int k = 0; k < 600; k++) begin
      idle_inputs();
      start      = ($urandom_range(0, 7) == 0);
      cfg_len    = 8'($urandom_range(0, 5));
      prod_valid = ($urandom_range(0, 9) < 7);
      prod       = ($urandom_range(0, 3) == 0) ? ONES : {$urandom, $urandom};
      out_ready  = ($urandom_range(0, 9) < 7);
      clr_err    = ($urandom_range(0, 15) == 0);
      tick();
    end

    idle_inputs();
    out_ready = 1;
    do_idle(4);
    chk("drain_empty", {64'd0, 8'(q.size())}, 72'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
